// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants: IF/ID register layout and canonical NOP.
// Reused by the fetch and decode stages.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/pc_gen.sv
// Program counter register and next-PC selection: redirect beats stall, otherwise sequential +4.
module pc_gen #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (redirect_valid_i) begin
            // Word-align the target; misaligned fetch is not trapped here.
            pc_d = redirect_pc_i & ~XLEN'(3);
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PC, instruction-memory address and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetched/bubble event counters.
module fetch_stage #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_DEPTH = 256,
    localparam int unsigned    AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [AW-1:0]   imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
    output logic            if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_bubbles_o
`endif
);

    import riscv_pkg::*;

    logic [XLEN-1:0] pc;
    logic            take_bubble;
    logic            take_fetch;

    logic [XLEN-1:0] if_id_pc_d, if_id_pc_q;
    logic [XLEN-1:0] if_id_pc4_d, if_id_pc4_q;
    logic [31:0]     if_id_instr_d, if_id_instr_q;
    logic            if_id_valid_d, if_id_valid_q;

    pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc)
    );

    assign take_bubble = redirect_valid_i | flush_i;
    assign take_fetch  = ~take_bubble & ~stall_i;

    // Upper PC bits are dropped, so the memory index wraps modulo IMEM_DEPTH.
    assign imem_addr_o = pc[AW+1:2];

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (take_bubble) begin
            if_id_pc_d    = '0;
            if_id_pc4_d   = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (take_fetch) begin
            if_id_pc_d    = pc;
            if_id_pc4_d   = pc + XLEN'(4);
            if_id_instr_d = imem_rdata_i;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_pc_q    <= '0;
            if_id_pc4_q   <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign fetch_pc_o    = pc;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_pc4_o   = if_id_pc4_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_d, perf_fetched_q;
    logic [31:0] perf_bubbles_d, perf_bubbles_q;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, take_fetch};
        perf_bubbles_d = perf_bubbles_q + {31'd0, take_bubble};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_bubbles_o = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF/ID + PC per edge
// into a scoreboard queue; each test task pops and compares after the edge.
module tb_fetch_stage;

    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned AW         = 8;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] fpc;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } obs_t;

    logic          clk;
    logic          rst;
    logic          stall_i;
    logic          flush_i;
    logic          redirect_valid_i;
    logic [31:0]   redirect_pc_i;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_rdata_i;
    logic [31:0]   fetch_pc_o;
    logic [31:0]   if_id_pc_o;
    logic [31:0]   if_id_pc4_o;
    logic [31:0]   if_id_instr_o;
    logic          if_id_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched_o;
    logic [31:0]   perf_bubbles_o;
`endif

    logic [31:0] mem [IMEM_DEPTH];
    assign imem_rdata_i = mem[imem_addr_o];

    fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .fetch_pc_o       (fetch_pc_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc4_o      (if_id_pc4_o),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_valid_o    (if_id_valid_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o   (perf_fetched_o),
        .perf_bubbles_o   (perf_bubbles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    obs_t exp_q[$];
    logic [31:0] m_pc;
    obs_t        m_ifid;   // fpc field unused in the model's IF/ID copy

    function automatic obs_t observe();
        obs_t o;
        o.fpc   = fetch_pc_o;
        o.pc    = if_id_pc_o;
        o.pc4   = if_id_pc4_o;
        o.instr = if_id_instr_o;
        o.valid = if_id_valid_o;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o.fpc   = 32'h0;
        o.pc    = 32'h0;
        o.pc4   = 32'h0;
        o.instr = NOP;
        o.valid = 1'b0;
        return o;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_ifid = reset_obs();
    endtask

    // Predict one edge, push the expectation, then drive the DUT through that edge.
    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        obs_t e;
        if (rv || fl) begin
            m_ifid = reset_obs();
        end else if (!st) begin
            m_ifid.pc    = m_pc;
            m_ifid.pc4   = m_pc + 32'd4;
            m_ifid.instr = mem[m_pc[AW+1:2]];
            m_ifid.valid = 1'b1;
        end
        if (rv)       m_pc = {rpc[31:2], 2'b00};
        else if (!st) m_pc = m_pc + 32'd4;
        e       = m_ifid;
        e.fpc   = m_pc;
        exp_q.push_back(e);
        stall_i          = st;
        flush_i          = fl;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        @(posedge clk);
        #1;
        stall_i          = 1'b0;
        flush_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        got = observe();
        compared++;
        if (got !== reset_obs()) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected %h", got, reset_obs());
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_straight_line();
        obs_t got, e;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            got = observe();
            e   = exp_q.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL straight_line[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_stall();
        obs_t got, e;
        // redirect to 4, fetch once (pc_q=8), stall twice, resume
        logic [2:0] st_tab [5] = '{3'b001, 3'b000, 3'b100, 3'b100, 3'b000};
        for (int i = 0; i < 5; i++) begin
            step(st_tab[i][2], st_tab[i][1], st_tab[i][0], 32'h4);
            got = observe();
            e   = exp_q.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL stall[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_redirect();
        obs_t got, e;
        logic [31:0] tgt [3] = '{32'h8, 32'h23, 32'h0};
        logic        rv  [3] = '{1'b1, 1'b1, 1'b0};
        step(1'b0, 1'b0, 1'b1, 32'h8);
        void'(exp_q.pop_front());
        step(1'b0, 1'b0, 1'b0, 32'h0);   // pc_q = 0xC
        void'(exp_q.pop_front());
        for (int i = 1; i < 3; i++) begin
            step(1'b0, 1'b0, rv[i], tgt[i]);
            got = observe();
            e   = exp_q.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL redirect[%0d]: got %h expected %h", i, got, e);
            end
        end
        compared++;
        if (if_id_pc_o !== 32'h20) begin
            mismatched++;
            $display("FAIL redirect_target_pc: got %h expected %h", if_id_pc_o, 32'h20);
        end
    endtask

    task automatic test_redirect_stall();
        obs_t got, e;
        // {stall, flush, redirect}: redirect+stall, flush+stall, flush alone, normal
        logic [2:0] tab [4] = '{3'b101, 3'b110, 3'b010, 3'b000};
        step(1'b0, 1'b0, 1'b0, 32'h0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(tab[i][2], tab[i][1], tab[i][0], 32'h0000_0104);
            got = observe();
            e   = exp_q.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL redirect_stall[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t got, e;
        logic [AW-1:0] exp_addr;
        exp_addr = AW'(IMEM_DEPTH - 1);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        got = observe();
        e   = exp_q.pop_front();
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL wrap_redirect: got %h expected %h", got, e);
        end
        compared++;
        if (imem_addr_o !== exp_addr) begin
            mismatched++;
            $display("FAIL wrap_imem_addr: got %h expected %h", imem_addr_o, exp_addr);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            got = observe();
            e   = exp_q.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL wrap_fetch[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        step(1'b0, 1'b0, 1'b1, 32'h3C);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.delete();
        compared++;
        if (fetch_pc_o !== 32'h40) begin
            mismatched++;
            $display("FAIL async_reset_setup: got %h expected %h", fetch_pc_o, 32'h40);
        end
        #2;
        rst = 1'b0;
        #1;
        got = observe();
        compared++;
        if (got !== reset_obs()) begin
            mismatched++;
            $display("FAIL async_reset: got %h expected %h", got, reset_obs());
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = observe();
        compared++;
        if (got !== exp_q[0]) begin
            mismatched++;
            $display("FAIL first_fetch_after_reset: got %h expected %h", got, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (perf_fetched_o !== 32'd0 || perf_bubbles_o !== 32'd0) begin
            mismatched++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_fetched_o, perf_bubbles_o);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, (i == 4 || i == 9), 32'h80);
        end
        exp_q.delete();
        compared++;
        if (perf_fetched_o !== 32'd10) begin
            mismatched++;
            $display("FAIL perf_fetched: got %0d expected 10", perf_fetched_o);
        end
        compared++;
        if (perf_bubbles_o !== 32'd2) begin
            mismatched++;
            $display("FAIL perf_bubbles: got %0d expected 2", perf_bubbles_o);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_8133;
        mem[2] = 32'h0011_02B3;
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
